// File: rtl/inst_sequencer_pkg.sv
// Shared constants, entry field layout and state type for the instruction sequencer.
package inst_sequencer_pkg;

    localparam int ADDR_W         = 4;
    localparam int ENTRY_W        = 8;
    localparam int OP_W           = 3;
    localparam int RPT_W          = 5;
    localparam int PEND_W         = 4;
    localparam int PIPE_DELAY_DEF = 7;

    // Entry layout: {opcode[7:5], rpt[4:0]}
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int RPT_MSB = 4;
    localparam int RPT_LSB = 0;

    localparam logic [OP_W-1:0] OP_LOAD   = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD    = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB    = 3'b010;
    localparam logic [OP_W-1:0] OP_MUL    = 3'b100;
    localparam logic [OP_W-1:0] OP_MULADD = 3'b101;
    localparam logic [OP_W-1:0] OP_MULSUB = 3'b110;
    localparam logic [OP_W-1:0] OP_MAX    = 3'b111;

    localparam logic [PEND_W-1:0] PEND_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    function automatic logic [OP_W-1:0] entry_op(input logic [ENTRY_W-1:0] e);
        return e[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [RPT_W-1:0] entry_rpt(input logic [ENTRY_W-1:0] e);
        return e[RPT_MSB:RPT_LSB];
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: small distributed RAM, synchronous write, asynchronous read.
module seq_prog_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents survive reset on purpose so a program can be rerun.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: steps through a stored program, issuing each entry
// rpt+1 times to a downstream decoder, then waits for all results to return.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | program memory writable, waiting for start
//   ST_RUN   | issuing entries 0..prog_last, one per unstalled cycle
//   ST_DRAIN | all issued, waiting for pending to reach zero
//   ST_DONE  | one-cycle completion, done asserted, back to idle
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic [3:0] prog_last,
    input  logic       start,
    input  logic       stall,
    input  logic       res_v,
    output logic       inst_v,
    output logic [2:0] opcode,
    output logic       busy,
    output logic       done,
    output logic [3:0] pending,
    output logic       err
);

    // The pending counter saturates at 15, so a deeper pipeline could not be tracked.
    if (PIPE_DELAY < 1 || PIPE_DELAY > int'(PEND_MAX)) begin : g_bad_delay
        $error("inst_sequencer: PIPE_DELAY out of range for pending counter");
    end

    seq_state_t          state, state_nx;
    logic [ADDR_W-1:0]   pc, pc_nx;
    logic [ADDR_W-1:0]   last_q, last_nx;
    logic [RPT_W-1:0]    rep, rep_nx;
    logic                inst_v_nx;
    logic [OP_W-1:0]     opcode_nx;
    logic                busy_nx;
    logic                done_nx;
    logic                mem_we;
    logic [ENTRY_W-1:0]  cur_entry;

    seq_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (cur_entry)
    );

    // State, sequencing counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            rep    <= '0;
            last_q <= '0;
            inst_v <= 1'b0;
            opcode <= OP_LOAD;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            rep    <= rep_nx;
            last_q <= last_nx;
            inst_v <= inst_v_nx;
            opcode <= opcode_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        rep_nx    = rep;
        last_nx   = last_q;
        inst_v_nx = 1'b0;
        opcode_nx = OP_LOAD;
        done_nx   = 1'b0;
        mem_we    = 1'b0;

        case (state)
            ST_IDLE: begin
                mem_we = prog_we;
                if (start) begin
                    last_nx  = prog_last;
                    pc_nx    = '0;
                    rep_nx   = '0;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    opcode_nx = opcode;
                end else begin
                    inst_v_nx = 1'b1;
                    opcode_nx = entry_op(cur_entry);
                    if (rep == entry_rpt(cur_entry)) begin
                        rep_nx = '0;
                        // pc parks on the last entry rather than wrapping.
                        if (pc == last_q) begin
                            state_nx = ST_DRAIN;
                        end else begin
                            pc_nx = pc + 1'b1;
                        end
                    end else begin
                        rep_nx = rep + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // inst_v is checked too: the final issue is still in flight
                // in the first drain cycle and not yet counted in pending.
                if (pending == '0 && !inst_v) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
    end

    // Outstanding-result counter with saturation, and sticky underflow error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            err     <= 1'b0;
        end else begin
            if (inst_v && !res_v && pending != PEND_MAX) begin
                pending <= pending + 1'b1;
            end else if (!inst_v && res_v && pending != '0) begin
                pending <= pending - 1'b1;
            end
            if (res_v && pending == '0) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: stimulus pushes the expected opcode
// stream, a negedge monitor predicts every output from a cycle-level model.
module tb_inst_sequencer;
    import inst_sequencer_pkg::*;

    localparam int PD = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] prog_last;
    logic       start;
    logic       stall;
    logic       res_v;
    logic       inst_v;
    logic [2:0] opcode;
    logic       busy;
    logic       done;
    logic [3:0] pending;
    logic       err;

    inst_sequencer #(.DEPTH(16), .PIPE_DELAY(PD)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_last (prog_last),
        .start     (start),
        .stall     (stall),
        .res_v     (res_v),
        .inst_v    (inst_v),
        .opcode    (opcode),
        .busy      (busy),
        .done      (done),
        .pending   (pending),
        .err       (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] shadow [16];
    logic [2:0] sb [$];

    // Reference model, describing the previous cycle when the monitor wakes.
    bit         m_active  = 0;   // a run is in progress, including its done cycle
    bit         m_done_ph = 0;
    bit         m_iv      = 0;
    logic [2:0] m_op      = 3'b000;
    int         m_pend    = 0;
    bit         m_err     = 0;

    bit [PD-1:0] pipe       = '0;
    bit          withhold   = 0;
    int          ret_budget = 0;
    bit          inject     = 0;

    int cyc = 0;
    int done_cnt = 0;
    int first_iv_cyc = -1;
    int done_cyc = -1;
    int iv_total = 0;
    int iv_run = 0;
    int iv_run_max = 0;
    int max_pend = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compare this cycle's outputs, advance the model, drive res_v.
    always @(negedge clk) begin : monitor
        bit         exp_iv, exp_done, exp_err, n_active, n_done_ph;
        logic [2:0] exp_op;
        int         exp_pend;
        cyc++;
        if (rst) begin
            chk("rst_inst_v", inst_v, 0);
            chk("rst_opcode", opcode, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_pending", pending, 0);
            chk("rst_err", err, 0);
            m_active = 0; m_done_ph = 0; m_iv = 0; m_op = 3'b000; m_pend = 0; m_err = 0;
            pipe = '0; ret_budget = 0; inject = 0;
            sb.delete();
            res_v = 1'b0;
        end else begin
            exp_pend = m_pend;
            exp_err  = m_err;
            if (res_v && m_pend == 0) exp_err = 1;
            if (m_iv && !res_v)      exp_pend = (m_pend < 15) ? m_pend + 1 : 15;
            else if (!m_iv && res_v) exp_pend = (m_pend > 0) ? m_pend - 1 : 0;

            exp_iv = 0; exp_op = 3'b000; exp_done = 0;
            if (m_active && !m_done_ph) begin
                if (sb.size() > 0) begin
                    if (!stall) begin
                        exp_iv = 1;
                        exp_op = sb.pop_front();
                    end else begin
                        exp_op = m_op;
                    end
                end else if (m_pend == 0 && !m_iv) begin
                    exp_done = 1;
                end
            end

            n_active = m_active; n_done_ph = m_done_ph;
            if (!m_active && start) begin
                n_active = 1; n_done_ph = 0;
            end else if (m_done_ph) begin
                n_active = 0; n_done_ph = 0;
            end else if (exp_done) begin
                n_done_ph = 1;
            end

            chk("inst_v", inst_v, exp_iv);
            chk("opcode", opcode, exp_op);
            chk("busy", busy, n_active && !n_done_ph);
            chk("done", done, exp_done);
            chk("pending", pending, exp_pend);
            chk("err", err, exp_err);

            m_active = n_active; m_done_ph = n_done_ph;
            m_iv = exp_iv; m_op = exp_op; m_pend = exp_pend; m_err = exp_err;

            if (withhold) begin
                res_v = (ret_budget > 0);
                if (ret_budget > 0) ret_budget--;
            end else begin
                res_v = pipe[PD-1];
            end
            if (inject) begin
                res_v = 1'b1;
                inject = 0;
            end
            pipe = {pipe[PD-2:0], (inst_v === 1'b1)};
        end

        if (inst_v === 1'b1) begin
            iv_total++;
            iv_run++;
            if (first_iv_cyc < 0) first_iv_cyc = cyc;
        end else begin
            iv_run = 0;
        end
        if (iv_run > iv_run_max) iv_run_max = iv_run;
        if (int'(pending) > max_pend) max_pend = int'(pending);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_stats();
        first_iv_cyc = -1; done_cyc = -1; iv_total = 0;
        iv_run_max = 0; max_pend = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic start_run(input int last);
        for (int i = 0; i <= last; i++)
            for (int r = 0; r <= int'(shadow[i][4:0]); r++)
                sb.push_back(shadow[i][7:5]);
        prog_last = 4'(last);
        start = 1'b1;
        tick();
        start = 1'b0;
        prog_last = 4'($urandom);
    endtask

    // mode 0: random stall (pct), 1: stall cycles 2..4, 2: start/prog_we abuse
    task automatic finish_run(input int mode, input int pct, input int budget);
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < budget; c++) begin
            start = 1'b0; prog_we = 1'b0; stall = 1'b0;
            if (mode == 1) begin
                stall = (c >= 2 && c <= 4);
            end else if (mode == 0) begin
                stall = ($urandom_range(0, 99) < pct);
            end else begin
                if (c == 1) begin
                    start = 1'b1; prog_last = 4'hF;
                    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hFF;
                end
                if (c == 3) begin
                    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h5A;
                end
            end
            tick();
            if (done_cnt != d0) break;
        end
        stall = 1'b0; start = 1'b0; prog_we = 1'b0;
        chk("done_seen", 8'(done_cnt - d0), 1);
        chk("sb_empty", 8'(sb.size()), 0);
        tick();
    endtask

    initial begin
        int last, pct;
        rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_last = '0; start = 1'b0; stall = 1'b0; res_v = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic two-entry program: MUL x1, ADD x3.
        write_entry(4'd0, {OP_MUL, 5'd0});
        write_entry(4'd1, {OP_ADD, 5'd2});
        clr_stats();
        start_run(1);
        finish_run(0, 0, 60);
        chk("issue_count", 8'(iv_total), 4);
        chk("done_latency", 8'(done_cyc - first_iv_cyc), 12);

        // Stall during the second ADD.
        clr_stats();
        start_run(1);
        finish_run(1, 0, 60);
        chk("stall_issue_count", 8'(iv_total), 4);
        chk("stall_pend_peak", 8'(max_pend), 4);

        // start and prog_we during RUN are ignored; rerun proves memory intact.
        clr_stats();
        start_run(1);
        finish_run(2, 0, 60);
        chk("abuse_issue_count", 8'(iv_total), 4);
        start_run(1);
        finish_run(0, 0, 60);

        // Stray result while idle sets sticky err.
        inject = 1;
        repeat (3) tick();
        chk("idle_err", err, 1);
        chk("idle_pending", pending, 0);
        repeat (5) tick();
        chk("err_sticky", err, 1);
        do_reset();
        chk("err_cleared", err, 0);

        // Reset mid-run with three results outstanding, then rerun.
        start_run(1);
        for (int c = 0; c < 20 && pending != 4'd3; c++) tick();
        chk("pend_reach3", pending, 3);
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_pending", pending, 0);
        tick();
        rst = 1'b0;
        tick();
        clr_stats();
        start_run(1);
        finish_run(0, 0, 60);
        chk("rerun_issue_count", 8'(iv_total), 4);

        // 32 back-to-back issues with results withheld.
        write_entry(4'd0, {OP_MAX, 5'd31});
        withhold = 1;
        clr_stats();
        start_run(0);
        for (int c = 0; c < 80 && !(iv_total >= 32 && inst_v == 1'b0); c++) tick();
        chk("long_run", 8'(iv_run_max), 32);
        chk("pend_sat", pending, 15);
        ret_budget = 15;
        finish_run(0, 0, 60);
        chk("sat_no_err", err, 0);
        withhold = 0;

        // Randomised programs with random stall.
        for (int t = 0; t < 20; t++) begin
            last = $urandom_range(0, 15);
            for (int a = 0; a <= last; a++) begin
                logic [4:0] rpt;
                rpt = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
                write_entry(4'(a), {3'($urandom), rpt});
            end
            pct = $urandom_range(0, 40);
            start_run(last);
            finish_run(0, pct, 2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
